// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem reads and queues returns for IF/ID.
// Optional feature macro FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exec,
    input  logic        is_halt_commanded,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] odata_instr,
    output logic [15:0] odata_pc,
    output logic        oflag_valid,
    output logic        ohalted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_stall
`endif
);

    localparam int            PW        = $clog2(QDEPTH);
    localparam logic [PW:0]   CNT_ZERO  = (PW+1)'(0);
    localparam logic [PW:0]   CNT_FULL  = (PW+1)'(QDEPTH);
    localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          resume_halt_q, resume_halt_d;
    logic          halt_base_s;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic [15:0]   instr_mem_q [QDEPTH];
    logic [15:0]   pc_mem_q    [QDEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          ack_s, push_s, pop_s, issue_s;

    // An ack only counts against a request we are actually holding.
    assign ack_s = imem_ack & req_q;

    // Run/halt/drop state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            resume_halt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            resume_halt_q <= resume_halt_d;
        end
    end

    // Next state: resolve halt/exec against the run/halt state we will return to, then apply drop.
    always_comb begin
        halt_base_s = (state_q == ST_DROP) ? resume_halt_q : (state_q == ST_HALT);
        if (is_halt_commanded) begin
            resume_halt_d = 1'b1;
        end else if (exec) begin
            resume_halt_d = ~halt_base_s;
        end else begin
            resume_halt_d = halt_base_s;
        end
        case (state_q)
            ST_DROP: state_d = ack_s ? (resume_halt_d ? ST_HALT : ST_RUN) : ST_DROP;
            ST_RUN, ST_HALT: begin
                if (redirect && req_q && !ack_s) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = resume_halt_d ? ST_HALT : ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Fetch datapath next values; issue decision uses post-edge state and occupancy.
    always_comb begin
        push_s  = ack_s && (state_q != ST_DROP) && !redirect;
        pop_s   = (count_q != CNT_ZERO) && !stall && !redirect;
        if (redirect) begin
            count_d = CNT_ZERO;
        end else begin
            count_d = count_q + (PW+1)'(push_s) - (PW+1)'(pop_s);
        end
        issue_s = !redirect && (state_d == ST_RUN) && (!req_q || ack_s) && (count_d < CNT_FULL);
        req_d   = issue_s | (req_q & ~ack_s);
        addr_d  = issue_s ? pc_q : addr_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue_s) begin
            pc_d = pc_q + 16'h0001;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC, request and prefetch queue storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            for (int i = 0; i < QDEPTH; i++) begin
                instr_mem_q[i] <= 16'h0000;
                pc_mem_q[i]    <= 16'h0000;
            end
        end else begin
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            count_q <= count_d;
            if (redirect) begin
                rd_ptr_q <= PTR_ZERO;
                wr_ptr_q <= PTR_ZERO;
            end else begin
                if (push_s) begin
                    instr_mem_q[wr_ptr_q] <= imem_rdata;
                    pc_mem_q[wr_ptr_q]    <= addr_q;
                    wr_ptr_q              <= wr_ptr_q + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
            end
        end
    end

    // Outputs decoded straight from registers.
    always_comb begin
        oflag_valid = (count_q != CNT_ZERO);
        if (oflag_valid) begin
            odata_instr = instr_mem_q[rd_ptr_q];
            odata_pc    = pc_mem_q[rd_ptr_q];
        end else begin
            odata_instr = 16'h0000;
            odata_pc    = 16'h0000;
        end
        ohalted   = (state_q == ST_HALT);
        imem_req  = req_q;
        imem_addr = addr_q;
    end

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched_q, perf_stall_q;

    // Saturating counters of accepted words and stalled-valid cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= 16'h0000;
            perf_stall_q   <= 16'h0000;
        end else begin
            if (push_s && (perf_fetched_q != 16'hFFFF)) begin
                perf_fetched_q <= perf_fetched_q + 16'h0001;
            end
            if (stall && (count_q != CNT_ZERO) && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'h0001;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, redirect drop, halt/exec, PC wrap, reset mid-request.
module tb_fetch_stage;

    logic        clock, reset, exec, is_halt_commanded, stall, redirect;
    logic [15:0] redirect_pc;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, imem_rdata;
    logic [15:0] odata_instr, odata_pc;
    logic        oflag_valid, ohalted;
    logic        req2, ack2, valid2, halted2;
    logic [15:0] addr2, rdata2, instr2, pc2;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

    int vectors = 0;
    int miscompares = 0;
    int lat1, cnt1, cnt2;
    logic [15:0] obs_pc[$], obs_in[$], obs2_pc[$], obs2_in[$];

    fetch_stage #(.RESET_PC(16'h0000), .QDEPTH(2)) u_dut (
        .clock(clock), .reset(reset), .exec(exec), .is_halt_commanded(is_halt_commanded),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .odata_instr(odata_instr), .odata_pc(odata_pc), .oflag_valid(oflag_valid), .ohalted(ohalted)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    fetch_stage #(.RESET_PC(16'hFFFE), .QDEPTH(2)) u_dut_wrap (
        .clock(clock), .reset(reset), .exec(1'b0), .is_halt_commanded(1'b0),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
        .odata_instr(instr2), .odata_pc(pc2), .oflag_valid(valid2), .ohalted(halted2)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched2), .perf_stall(perf_stall2)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory answering l cycles after it first sees a request, rdata = addr + 0x1000.
    task automatic mem_tick(input logic rst, input logic req, input logic [15:0] addr, input int l,
                            input logic ack_i, input logic [15:0] rd_i, input int c_i,
                            output logic ack_o, output logic [15:0] rd_o, output int c_o);
        ack_o = 1'b0;
        rd_o  = rd_i;
        c_o   = c_i;
        if (!rst) begin
            c_o = 0;
        end else if (ack_i) begin
            c_o = req ? 1 : 0;
        end else if (req) begin
            c_o = c_i + 1;
            if (c_o > l) begin
                ack_o = 1'b1;
                rd_o  = addr + 16'h1000;
            end
        end else begin
            c_o = 0;
        end
    endtask

    // Record heads that the next rising edge will pop, then advance to the next falling edge.
    task automatic step();
        if (reset && oflag_valid && !stall && !redirect) begin
            obs_pc.push_back(odata_pc);
            obs_in.push_back(odata_instr);
        end
        if (reset && valid2) begin
            obs2_pc.push_back(pc2);
            obs2_in.push_back(instr2);
        end
        @(negedge clock);
        mem_tick(reset, imem_req, imem_addr, lat1, imem_ack, imem_rdata, cnt1, imem_ack, imem_rdata, cnt1);
        mem_tick(reset, req2, addr2, 1, ack2, rdata2, cnt2, ack2, rdata2, cnt2);
    endtask

    initial begin
        lat1 = 1; cnt1 = 0; cnt2 = 0;
        reset = 1'b0; exec = 1'b0; is_halt_commanded = 1'b0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 16'h0000;
        imem_ack = 1'b0; imem_rdata = 16'h0000; ack2 = 1'b0; rdata2 = 16'h0000;
        repeat (2) step();

        chk("rst_valid", 32'(oflag_valid), 32'd0);
        chk("rst_pc", 32'(odata_pc), 32'h0);
        chk("rst_instr", 32'(odata_instr), 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk("rst_halted", 32'(ohalted), 32'd0);
        chk("rst_addr_wrap", 32'(addr2), 32'hFFFE);
        chk("rst_halted_wrap", 32'(halted2), 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", 32'(perf_fetched), 32'd0);
        chk("rst_perf_stall", 32'(perf_stall), 32'd0);
        chk("rst_perf_wrap", 32'(perf_stall2 | perf_fetched2), 32'd0);
`endif

        // Release with a stray ack while no request is held: must be ignored.
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        for (int i = 0; i < 100 && obs_pc.size() < 3; i++) step();
        chk("boot_count", 32'(obs_pc.size()), 32'd3);
        chk("boot_pc0", 32'(obs_pc[0]), 32'h0000);
        chk("boot_in0", 32'(obs_in[0]), 32'h1000);
        chk("boot_pc1", 32'(obs_pc[1]), 32'h0001);
        chk("boot_in1", 32'(obs_in[1]), 32'h1001);
        chk("boot_pc2", 32'(obs_pc[2]), 32'h0002);
        chk("boot_in2", 32'(obs_in[2]), 32'h1002);

        stall = 1'b1;
        repeat (5) step();
        chk("stall_valid", 32'(oflag_valid), 32'd1);
        chk("stall_head_pc", 32'(odata_pc), 32'h0003);
        chk("stall_head_in", 32'(odata_instr), 32'h1003);
        chk("stall_full_noreq", 32'(imem_req), 32'd0);
        chk("stall_nopop", 32'(obs_pc.size()), 32'd3);

        stall = 1'b0; lat1 = 4;
        for (int i = 0; i < 100 && obs_pc.size() < 5; i++) step();
        chk("unstall_pc3", 32'(obs_pc[3]), 32'h0003);
        chk("unstall_pc4", 32'(obs_pc[4]), 32'h0004);
        chk("unstall_in4", 32'(obs_in[4]), 32'h1004);
        chk("pre_redir_req", 32'(imem_req), 32'd1);
        chk("pre_redir_addr", 32'(imem_addr), 32'h0005);

        redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        chk("redir_valid", 32'(oflag_valid), 32'd0);
        chk("drop_req_held", 32'(imem_req), 32'd1);
        chk("drop_addr_held", 32'(imem_addr), 32'h0005);
        repeat (2) step();
        chk("drop_not_halted", 32'(ohalted), 32'd0);
        lat1 = 1;
        for (int i = 0; i < 100 && obs_pc.size() < 6; i++) step();
        chk("redir_pc", 32'(obs_pc[5]), 32'h0040);
        chk("redir_in", 32'(obs_in[5]), 32'h1040);

        is_halt_commanded = 1'b1;
        step();
        is_halt_commanded = 1'b0;
        chk("halt_flag", 32'(ohalted), 32'd1);
        chk("halt_noreq", 32'(imem_req), 32'd0);
        repeat (6) step();
        chk("halt_drained_cnt", 32'(obs_pc.size()), 32'd7);
        chk("halt_last_pc", 32'(obs_pc[6]), 32'h0041);
        chk("halt_last_in", 32'(obs_in[6]), 32'h1041);
        chk("halt_idle_req", 32'(imem_req), 32'd0);
        chk("halt_idle_valid", 32'(oflag_valid), 32'd0);

        exec = 1'b1; is_halt_commanded = 1'b1;
        step();
        exec = 1'b0; is_halt_commanded = 1'b0;
        chk("halt_wins_flag", 32'(ohalted), 32'd1);
        chk("halt_wins_req", 32'(imem_req), 32'd0);

        exec = 1'b1;
        step();
        exec = 1'b0;
        chk("exec_run_flag", 32'(ohalted), 32'd0);
        chk("exec_req", 32'(imem_req), 32'd1);
        chk("exec_addr", 32'(imem_addr), 32'h0042);
        for (int i = 0; i < 100 && obs_pc.size() < 8; i++) step();
        chk("resume_pc", 32'(obs_pc[7]), 32'h0042);
        chk("resume_in", 32'(obs_in[7]), 32'h1042);

        chk("wrap_count_ok", 32'(obs2_pc.size() >= 3), 32'd1);
        chk("wrap_pc0", 32'(obs2_pc[0]), 32'hFFFE);
        chk("wrap_in0", 32'(obs2_in[0]), 32'h0FFE);
        chk("wrap_pc1", 32'(obs2_pc[1]), 32'hFFFF);
        chk("wrap_pc2", 32'(obs2_pc[2]), 32'h0000);
        chk("wrap_in2", 32'(obs2_in[2]), 32'h1000);

        for (int i = 0; i < 20 && !imem_req; i++) step();
        chk("midreq_req_seen", 32'(imem_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_addr", 32'(imem_addr), 32'h0000);
        chk("midrst_valid", 32'(oflag_valid), 32'd0);
        chk("midrst_halted", 32'(ohalted), 32'd0);
`ifdef FETCH_PERF_EN
        chk("midrst_perf", 32'(perf_fetched), 32'd0);
`endif
        repeat (2) step();
        obs_pc.delete(); obs_in.delete();
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        for (int i = 0; i < 100 && obs_pc.size() < 3; i++) step();
        chk("reboot_pc0", 32'(obs_pc[0]), 32'h0000);
        chk("reboot_in0", 32'(obs_in[0]), 32'h1000);
        chk("reboot_pc2", 32'(obs_pc[2]), 32'h0002);

        for (int i = 0; i < 20 && !oflag_valid; i++) step();
        stall = 1'b1;
        repeat (4) step();
        stall = 1'b0;
        chk("stall4_head", 32'(odata_pc), 32'h0003);

        // Redirect on the very cycle the pending word is acked: that word is discarded.
        for (int i = 0; i < 20 && (oflag_valid || !imem_req); i++) step();
        chk("ackredir_ready", 32'(imem_req & ~oflag_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 100 && obs_pc.size() < 6; i++) step();
        chk("ackredir_pc3", 32'(obs_pc[3]), 32'h0003);
        chk("ackredir_pc4", 32'(obs_pc[4]), 32'h0004);
        chk("ackredir_pc", 32'(obs_pc[5]), 32'h0100);
        chk("ackredir_in", 32'(obs_in[5]), 32'h1100);
        is_halt_commanded = 1'b1;
        step();
        is_halt_commanded = 1'b0;
        repeat (6) step();
        chk("final_count", 32'(obs_pc.size()), 32'd7);
        chk("final_pc", 32'(obs_pc[6]), 32'h0101);
        chk("final_noreq", 32'(imem_req), 32'd0);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", 32'(perf_fetched), 32'd7);
        chk("perf_stall", 32'(perf_stall), 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
